reg_scoreboard: RTL and testbench

- Issue-side scoreboard sequencing access to the RV32I 32-entry register file (x0 hardwired zero, 2 comb read ports, 1 clocked write port).
- Tracks destination registers of in-flight instructions, including variable-latency extension units. Stalls issue on RAW/WAW hazards and on an outstanding-write limit.
- Provides a drain handshake for fence/ecall/CSR sequencing.

---
 rtl/r32i_pkg.sv | 42 ++++
 rtl/reg_scoreboard_if.sv | 46 ++++
 rtl/reg_scoreboard.sv | 107 ++++++++++
 tb/tb_reg_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/r32i_pkg.sv
// ============================================================================
// Module : r32i_pkg
// Shared RV32I register-file types, state encoding and the issue hazard check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package r32i_pkg;

  localparam int NumRegs  = 32;
  localparam int RegAddrW = 5;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SB_RUN     = 2'd0,
    SB_DRAIN   = 2'd1,
    SB_DRAINED = 2'd2
  } sb_state_t;

  // Kept here so decode can reuse the exact same stall rule.
  function automatic logic sb_hazard(
    input logic [NumRegs-1:0] busy,
    input logic               uses_rs1,
    input reg_addr_t          rs1,
    input logic               uses_rs2,
    input reg_addr_t          rs2,
    input logic               writes_rd,
    input reg_addr_t          rd,
    input logic               at_limit
  );
    logic src_haz;
    logic dst_haz;
    src_haz = (uses_rs1 && (rs1 != '0) && busy[rs1]) ||
              (uses_rs2 && (rs2 != '0) && busy[rs2]);
    dst_haz = writes_rd && (rd != '0) && (busy[rd] || at_limit);
    return src_haz || dst_haz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// Module : reg_scoreboard_if
// Issue, writeback, flush and drain signals between decode and the scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int MaxOutstanding = 4
);
  import r32i_pkg::*;

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic                 issue_valid;
  logic                 issue_ready;
  reg_addr_t            issue_rs1;
  reg_addr_t            issue_rs2;
  logic                 issue_uses_rs1;
  logic                 issue_uses_rs2;
  reg_addr_t            issue_rd;
  logic                 issue_writes_rd;
  logic                 wb_valid;
  reg_addr_t            wb_rd;
  logic                 flush;
  logic                 drain_req;
  logic                 drain_done;
  logic [NumRegs-1:0]   busy_mask;
  logic [CntW-1:0]      outstanding;
  logic                 sb_error;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
           issue_rd, issue_writes_rd, wb_valid, wb_rd, flush, drain_req,
    input  issue_ready, drain_done, busy_mask, outstanding, sb_error
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
           issue_rd, issue_writes_rd, wb_valid, wb_rd, flush, drain_req,
    output issue_ready, drain_done, busy_mask, outstanding, sb_error
  );

endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module : reg_scoreboard
// Issue-side busy-register scoreboard with outstanding-write limit and drain FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import r32i_pkg::*;
#(
  parameter int dataW          = 32,
  parameter int MaxOutstanding = 4
) (
  input  wire             clock,
  input  wire             reset,
  reg_scoreboard_if.slave sb
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  if (($clog2(dataW) != RegAddrW) || (MaxOutstanding < 1) || (MaxOutstanding > 15))
  begin : g_bad_cfg
    $error("reg_scoreboard: unsupported dataW/MaxOutstanding");
  end

  sb_state_t          state_q, state_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    outstanding_q, outstanding_d;
  logic               error_q, error_d;
  logic               drain_done_q, drain_done_d;

  logic w_at_limit;
  logic w_hazard;
  logic w_ready;
  logic w_inc;
  logic w_wb;
  logic w_wb_hit;

  assign w_at_limit = (outstanding_q == CntW'(MaxOutstanding));
  assign w_hazard   = sb_hazard(busy_q, sb.issue_uses_rs1, sb.issue_rs1,
                                sb.issue_uses_rs2, sb.issue_rs2,
                                sb.issue_writes_rd, sb.issue_rd, w_at_limit);
  assign w_inc      = sb.issue_valid && w_ready && sb.issue_writes_rd && (sb.issue_rd != '0);
  assign w_wb       = sb.wb_valid && (sb.wb_rd != '0);
  assign w_wb_hit   = w_wb && busy_q[sb.wb_rd];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SB_RUN;
      busy_q        <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      drain_done_q  <= drain_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_RUN:     if (sb.drain_req) state_d = SB_DRAIN;
      SB_DRAIN: begin
        if (!sb.drain_req)              state_d = SB_RUN;
        else if (outstanding_q == '0)   state_d = SB_DRAINED;
      end
      SB_DRAINED: if (!sb.drain_req) state_d = SB_RUN;
      default:    state_d = SB_RUN;
    endcase
  end

  // Flush wins over issue and writeback; the error flag survives it.
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;
    if (sb.flush) begin
      busy_d        = '0;
      outstanding_d = '0;
    end else begin
      if (w_inc)    busy_d[sb.issue_rd] = 1'b1;
      if (w_wb_hit) busy_d[sb.wb_rd]    = 1'b0;
      if (w_inc && !w_wb_hit)      outstanding_d = outstanding_q + CntW'(1);
      else if (!w_inc && w_wb_hit) outstanding_d = outstanding_q - CntW'(1);
      if (w_wb && !w_wb_hit) error_d = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    w_ready      = !reset && (state_q == SB_RUN) && !sb.flush && !w_hazard;
    drain_done_d = (state_d == SB_DRAINED);
  end

  assign sb.issue_ready = w_ready;
  assign sb.busy_mask   = busy_q;
  assign sb.outstanding = outstanding_q;
  assign sb.sb_error    = error_q;
  assign sb.drain_done  = drain_done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module : tb_reg_scoreboard
// Table-driven directed checks of issue stalls, writeback, flush and drain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  logic clock;
  logic reset;

  reg_scoreboard_if #(.MaxOutstanding(4)) sb_if ();

  reg_scoreboard #(.dataW(32), .MaxOutstanding(4)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic        urs1;
    logic [4:0]  rs1;
    logic        urs2;
    logic [4:0]  rs2;
    logic        wrd;
    logic [4:0]  rd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        flush;
    logic        drain;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [31:0] exp_busy;
    logic [2:0]  exp_out;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  // Issue-only row: fields, optional writeback, control, then post-edge state.
  task automatic add(input logic v, input logic u1, input int r1, input logic u2, input int r2,
                     input logic w, input int d, input logic wb, input int wr,
                     input logic fl, input logic dr, input logic cr, input logic er,
                     input logic [31:0] eb, input int eo, input logic ee, input logic ed);
    vec_t t;
    t.valid = v;  t.urs1 = u1; t.rs1 = 5'(r1); t.urs2 = u2; t.rs2 = 5'(r2);
    t.wrd = w;    t.rd = 5'(d); t.wbv = wb;    t.wbrd = 5'(wr);
    t.flush = fl; t.drain = dr; t.chk_rdy = cr; t.exp_rdy = er;
    t.exp_busy = eb; t.exp_out = 3'(eo); t.exp_err = ee; t.exp_done = ed;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    sb_if.issue_valid     = t.valid;
    sb_if.issue_uses_rs1  = t.urs1;
    sb_if.issue_rs1       = t.rs1;
    sb_if.issue_uses_rs2  = t.urs2;
    sb_if.issue_rs2       = t.rs2;
    sb_if.issue_writes_rd = t.wrd;
    sb_if.issue_rd        = t.rd;
    sb_if.wb_valid        = t.wbv;
    sb_if.wb_rd           = t.wbrd;
    sb_if.flush           = t.flush;
    sb_if.drain_req       = t.drain;
  endtask

  task automatic check_state(input logic [31:0] eb, input int eo, input logic ee, input logic ed);
    check("busy_mask", sb_if.busy_mask, eb);
    check("outstanding", 32'(sb_if.outstanding), 32'(eo));
    check("sb_error", 32'(sb_if.sb_error), 32'(ee));
    check("drain_done", 32'(sb_if.drain_done), 32'(ed));
  endtask

  initial begin
    vec_t idle;
    // RAW on x5: ready returns only the cycle after wb_rd=5
    add(1,0,0,0,0,1,5, 0,0, 0,0, 1,1, 32'h20,1,0,0);          // 0
    add(1,1,5,0,0,1,6, 0,0, 0,0, 1,0, 32'h20,1,0,0);
    add(1,1,5,0,0,1,6, 0,0, 0,0, 1,0, 32'h20,1,0,0);
    add(1,1,5,0,0,1,6, 0,0, 0,0, 1,0, 32'h20,1,0,0);
    add(1,1,5,0,0,1,6, 1,5, 0,0, 1,0, 32'h0,0,0,0);            // 4
    add(1,1,5,0,0,1,6, 0,0, 0,0, 1,1, 32'h40,1,0,0);
    add(0,0,0,0,0,0,0, 1,6, 0,0, 1,1, 32'h0,0,0,0);
    // x0 never tracked
    add(1,1,0,1,0,1,0, 1,0, 0,0, 1,1, 32'h0,0,0,0);            // 7
    add(1,1,0,1,0,1,0, 0,0, 0,0, 1,1, 32'h0,0,0,0);
    // outstanding limit
    add(1,0,0,0,0,1,1, 0,0, 0,0, 1,1, 32'h02,1,0,0);           // 9
    add(1,0,0,0,0,1,2, 0,0, 0,0, 1,1, 32'h06,2,0,0);
    add(1,0,0,0,0,1,3, 0,0, 0,0, 1,1, 32'h0E,3,0,0);
    add(1,0,0,0,0,1,4, 0,0, 0,0, 1,1, 32'h1E,4,0,0);
    add(1,0,0,0,0,1,6, 0,0, 0,0, 1,0, 32'h1E,4,0,0);           // 13
    add(1,0,0,0,0,1,6, 1,2, 0,0, 1,0, 32'h1A,3,0,0);
    add(1,0,0,0,0,1,6, 0,0, 0,0, 1,1, 32'h5A,4,0,0);
    // simultaneous accept + writeback at outstanding 2
    add(0,0,0,0,0,0,0, 1,3, 0,0, 1,1, 32'h52,3,0,0);           // 16
    add(0,0,0,0,0,0,0, 1,4, 0,0, 1,1, 32'h42,2,0,0);
    add(1,0,0,0,0,1,7, 1,1, 0,0, 1,1, 32'hC0,2,0,0);
    add(0,0,0,0,0,0,0, 1,6, 0,0, 1,1, 32'h80,1,0,0);
    add(0,0,0,0,0,0,0, 1,7, 0,0, 1,1, 32'h0,0,0,0);
    // spurious writeback, then flush keeps the error
    add(0,0,0,0,0,0,0, 1,9, 0,0, 1,1, 32'h0,0,1,0);            // 21
    add(1,0,0,0,0,1,3, 0,0, 0,0, 1,1, 32'h08,1,1,0);
    add(1,0,0,0,0,1,10,1,3, 1,0, 1,0, 32'h0,0,1,0);
    // drain with two outstanding
    add(1,0,0,0,0,1,1, 0,0, 0,0, 1,1, 32'h02,1,1,0);           // 24
    add(1,0,0,0,0,1,2, 0,0, 0,0, 1,1, 32'h06,2,1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,1, 0,0, 32'h06,2,1,0);
    add(1,0,0,0,0,1,8, 0,0, 0,1, 1,0, 32'h06,2,1,0);
    add(1,0,0,0,0,1,8, 1,1, 0,1, 1,0, 32'h04,1,1,0);
    add(1,0,0,0,0,1,8, 1,2, 0,1, 1,0, 32'h0,0,1,0);            // 29
    add(1,0,0,0,0,1,8, 0,0, 0,1, 1,0, 32'h0,0,1,1);
    add(1,0,0,0,0,1,8, 0,0, 0,1, 1,0, 32'h0,0,1,1);
    add(1,0,0,0,0,1,8, 0,0, 0,0, 1,0, 32'h0,0,1,0);
    add(1,0,0,0,0,1,8, 0,0, 0,0, 1,1, 32'h100,1,1,0);          // 33
    // drain interrupted by flush
    add(1,0,0,0,0,1,9, 0,0, 0,0, 1,1, 32'h300,2,1,0);
    add(0,0,0,0,0,0,0, 0,0, 0,1, 0,0, 32'h300,2,1,0);
    add(1,0,0,0,0,1,4, 0,0, 1,1, 1,0, 32'h0,0,1,0);            // 36
    add(0,0,0,0,0,0,0, 0,0, 0,1, 1,0, 32'h0,0,1,1);
    add(1,0,0,0,0,1,5, 0,0, 0,0, 1,0, 32'h0,0,1,0);
    add(1,0,0,0,0,1,5, 0,0, 0,0, 1,1, 32'h20,1,1,0);           // 39
    // drain request withdrawn before completion
    add(0,0,0,0,0,0,0, 0,0, 0,1, 0,0, 32'h20,1,1,0);
    add(1,0,0,0,0,1,6, 0,0, 0,0, 1,0, 32'h20,1,1,0);
    add(1,0,0,0,0,1,6, 0,0, 0,0, 1,1, 32'h60,2,1,0);
    // WAW and rs2 hazards, unused rs2 ignored
    add(1,0,0,0,0,1,5, 0,0, 0,0, 1,0, 32'h60,2,1,0);           // 43
    add(1,0,0,1,6,0,0, 0,0, 0,0, 1,0, 32'h60,2,1,0);
    add(1,0,0,0,6,0,0, 0,0, 0,0, 1,1, 32'h60,2,1,0);

    idle = '{default: '0};
    drive(idle);
    sb_if.issue_valid     = 1'b1;
    sb_if.issue_writes_rd = 1'b1;
    sb_if.issue_rd        = 5'd3;
    reset = 1'b1;
    #12;
    check("ready_in_reset", 32'(sb_if.issue_ready), 32'd0);
    check_state(32'h0, 0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(idle);

    foreach (tbl[i]) begin
      row = i;
      @(negedge clock);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_rdy) check("issue_ready", 32'(sb_if.issue_ready), 32'(tbl[i].exp_rdy));
      @(posedge clock);
      #1;
      check_state(tbl[i].exp_busy, 32'(tbl[i].exp_out), tbl[i].exp_err, tbl[i].exp_done);
    end

    // Asynchronous reset mid-cycle clears everything including the sticky error.
    row = -2;
    @(negedge clock);
    drive(idle);
    sb_if.issue_valid     = 1'b1;
    sb_if.issue_writes_rd = 1'b1;
    sb_if.issue_rd        = 5'd7;
    #2;
    reset = 1'b1;
    #1;
    check("ready_async_reset", 32'(sb_if.issue_ready), 32'd0);
    check_state(32'h0, 0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(sb_if.issue_ready), 32'd1);
    @(posedge clock);
    #1;
    check_state(32'h80, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
